pipeline_sequencer: RTL and testbench

//   Run/step/halt sequencer for the 5-stage MIPS pipeline.

---
 rtl/pipeline_sequencer_pkg.sv | 22 ++
 rtl/pipeline_sequencer_sat_counter.sv | 30 +++
 rtl/pipeline_sequencer.sv | 112 +++++++++++
 tb/tb_pipeline_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline run/step/halt sequencer.
//   - state encodings as seen on o_state
//   - debug command codes carried on i_cmd
package pipeline_sequencer_pkg;

    localparam int NB_CMD = 2;
    localparam int NB_ST  = 3;

    typedef enum logic [NB_ST-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [NB_CMD-1:0] CMD_CLEAR = 2'b00;
    localparam logic [NB_CMD-1:0] CMD_RUN   = 2'b01;
    localparam logic [NB_CMD-1:0] CMD_STEP  = 2'b10;
    localparam logic [NB_CMD-1:0] CMD_HALT  = 2'b11;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clock    rising-edge clock
//   i_reset_n  asynchronous active-low reset, count -> 0
//   i_enable   count up by one (holds at all-ones)
//   i_clear    synchronous clear, wins over i_enable
//   o_count    current count
module sat_counter #(
    parameter int NB = 32
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_enable,
    input  logic          i_clear,
    output logic [NB-1:0] o_count
);

    logic [NB-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable && (r_count != {NB{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline.
// Takes debug commands over valid/ready, gates PC and pipeline register
// updates, bubbles the control unit, drains the pipe after a decoded HALT
// and counts enabled cycles.
//   i_clock, i_reset_n        clock, async active-low reset
//   i_cmd_valid, i_cmd        command handshake (CLEAR_CNT/RUN/STEP/HALT)
//   o_cmd_ready               command can be accepted this cycle
//   i_halt_decoded            HALT opcode sitting in ID
//   o_pc_enable               PC and IF/ID update enable
//   o_pipe_enable             ID/EX, EX/MEM, MEM/WB update enable
//   o_bubble                  1 forces a zero control word
//   o_state                   current state encoding
//   o_cycle_count             saturating count of pipe-enabled cycles
//   o_step_done, o_done       single-cycle completion pulses
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int NB_CYCLES = 32,
    parameter int N_DRAIN   = 4,
    parameter int NB_STATE  = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_cmd_valid,
    input  logic [NB_CMD-1:0]    i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt_decoded,
    output logic                 o_pc_enable,
    output logic                 o_pipe_enable,
    output logic                 o_bubble,
    output logic [NB_STATE-1:0]  o_state,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic                 o_step_done,
    output logic                 o_done
);

    localparam int                  NB_DRAIN   = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(N_DRAIN - 1);

    state_t              r_state;
    state_t              w_next;
    logic [NB_DRAIN-1:0] r_drain;
    logic                r_step_done;
    logic                r_done;
    logic                w_accept;
    logic                w_clear;
    logic                w_exec;
    logic                w_drain_last;

    // RUN and STEP share the same Mealy gating on i_halt_decoded.
    assign w_exec       = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_drain_last = (r_state == ST_DRAIN) && (r_drain == DRAIN_LAST);

    assign o_cmd_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_HALTED);
    assign w_accept     = i_cmd_valid && o_cmd_ready;
    // CLEAR_CNT is a no-op in RUN, so it never races the increment.
    assign w_clear      = w_accept && (i_cmd == CMD_CLEAR) &&
                          ((r_state == ST_IDLE) || (r_state == ST_HALTED));

    assign o_pipe_enable = w_exec || (r_state == ST_DRAIN);
    assign o_pc_enable   = w_exec && !i_halt_decoded;
    assign o_bubble      = (w_exec && i_halt_decoded) || (r_state == ST_DRAIN);
    assign o_state       = NB_STATE'(r_state);
    assign o_step_done   = r_step_done;
    assign o_done        = r_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (i_cmd == CMD_RUN))
                    w_next = ST_RUN;
                else if (w_accept && (i_cmd == CMD_STEP))
                    w_next = ST_STEP;
            end
            ST_RUN: begin
                if (i_halt_decoded || (w_accept && (i_cmd == CMD_HALT)))
                    w_next = ST_DRAIN;
            end
            ST_STEP:   w_next = i_halt_decoded ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  if (w_drain_last) w_next = ST_HALTED;
            ST_HALTED: w_next = ST_HALTED;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_drain     <= '0;
            r_step_done <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            // Drain counter idles at 0 so it starts fresh on every DRAIN entry.
            r_drain     <= ((r_state == ST_DRAIN) && !w_drain_last) ? r_drain + 1'b1 : '0;
            r_step_done <= (r_state == ST_STEP) && !i_halt_decoded;
            r_done      <= w_drain_last;
        end
    end

    sat_counter #(
        .NB (NB_CYCLES)
    ) u_cycle_cnt (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_enable  (o_pipe_enable),
        .i_clear   (w_clear),
        .o_count   (o_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus random traffic,
// every cycle compared against a cycle-level behavioural model.
// An 8-bit counter keeps the saturation scenario short.
module tb_pipeline_sequencer;

    localparam int NB_CYCLES = 8;
    localparam int N_DRAIN   = 4;
    localparam int NB_STATE  = 3;
    localparam int CNT_MAX   = (1 << NB_CYCLES) - 1;

    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_HALT  = 2'b11;

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

    logic                 i_clock;
    logic                 i_reset_n;
    logic                 i_cmd_valid;
    logic [1:0]           i_cmd;
    logic                 o_cmd_ready;
    logic                 i_halt_decoded;
    logic                 o_pc_enable;
    logic                 o_pipe_enable;
    logic                 o_bubble;
    logic [NB_STATE-1:0]  o_state;
    logic [NB_CYCLES-1:0] o_cycle_count;
    logic                 o_step_done;
    logic                 o_done;

    pipeline_sequencer #(
        .NB_CYCLES (NB_CYCLES),
        .N_DRAIN   (N_DRAIN),
        .NB_STATE  (NB_STATE)
    ) dut (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .i_cmd_valid    (i_cmd_valid),
        .i_cmd          (i_cmd),
        .o_cmd_ready    (o_cmd_ready),
        .i_halt_decoded (i_halt_decoded),
        .o_pc_enable    (o_pc_enable),
        .o_pipe_enable  (o_pipe_enable),
        .o_bubble       (o_bubble),
        .o_state        (o_state),
        .o_cycle_count  (o_cycle_count),
        .o_step_done    (o_step_done),
        .o_done         (o_done)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode, remaining drain cycles, count, pending pulses.
    int m_mode;
    int m_drain_left;
    int m_count;
    bit m_step_pulse;
    bit m_done_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_drain_left = 0;
        m_count      = 0;
        m_step_pulse = 0;
        m_done_pulse = 0;
    endtask

    function automatic bit m_ready();
        return (m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_HALTED);
    endfunction

    function automatic bit m_executing();
        return (m_mode == M_RUN) || (m_mode == M_STEP);
    endfunction

    task automatic check_outputs(input bit h);
        chk("state",     32'(o_state),       32'(m_mode));
        chk("ready",     32'(o_cmd_ready),   32'(m_ready()));
        chk("pipe_en",   32'(o_pipe_enable), 32'(m_executing() || m_mode == M_DRAIN));
        chk("pc_en",     32'(o_pc_enable),   32'(m_executing() && !h));
        chk("bubble",    32'(o_bubble),      32'((m_executing() && h) || m_mode == M_DRAIN));
        chk("count",     32'(o_cycle_count), 32'(m_count));
        chk("step_done", 32'(o_step_done),   32'(m_step_pulse));
        chk("done",      32'(o_done),        32'(m_done_pulse));
    endtask

    task automatic model_step(input bit v, input logic [1:0] c, input bit h);
        bit acc;
        int nxt;
        acc = v && m_ready();
        nxt = m_mode;
        if (m_executing() || m_mode == M_DRAIN)
            m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
        if (acc && c == C_CLEAR && (m_mode == M_IDLE || m_mode == M_HALTED))
            m_count = 0;
        m_step_pulse = (m_mode == M_STEP) && !h;
        m_done_pulse = (m_mode == M_DRAIN) && (m_drain_left == 1);
        case (m_mode)
            M_IDLE:   if (acc && c == C_RUN) nxt = M_RUN;
                      else if (acc && c == C_STEP) nxt = M_STEP;
            M_RUN:    if (h || (acc && c == C_HALT)) nxt = M_DRAIN;
            M_STEP:   nxt = h ? M_DRAIN : M_IDLE;
            M_DRAIN:  begin
                          m_drain_left--;
                          if (m_drain_left == 0) nxt = M_HALTED;
                      end
            default:  nxt = m_mode;
        endcase
        if (nxt == M_DRAIN && m_mode != M_DRAIN)
            m_drain_left = N_DRAIN;
        m_mode = nxt;
    endtask

    // Inputs change just after posedge; outputs compared at negedge.
    task automatic cycle(input bit v, input logic [1:0] c, input bit h);
        i_cmd_valid    = v;
        i_cmd          = c;
        i_halt_decoded = h;
        @(negedge i_clock);
        check_outputs(h);
        @(posedge i_clock);
        model_step(v, c, h);
        #1;
    endtask

    task automatic do_reset();
        i_cmd_valid    = 1'b0;
        i_cmd          = C_CLEAR;
        i_halt_decoded = 1'b0;
        i_reset_n      = 1'b0;
        #1;
        chk("rst_state",  32'(o_state),       32'd0);
        chk("rst_count",  32'(o_cycle_count), 32'd0);
        chk("rst_pc_en",  32'(o_pc_enable),   32'd0);
        chk("rst_pipe",   32'(o_pipe_enable), 32'd0);
        chk("rst_bubble", 32'(o_bubble),      32'd0);
        chk("rst_ready",  32'(o_cmd_ready),   32'd1);
        chk("rst_pulses", 32'({o_step_done, o_done}), 32'd0);
        model_reset();
        @(negedge i_clock);
        i_reset_n = 1'b1;
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        int done_seen;
        i_reset_n      = 1'b1;
        i_cmd_valid    = 1'b0;
        i_cmd          = C_CLEAR;
        i_halt_decoded = 1'b0;
        model_reset();
        #2;

        // 1: reset in the middle of RUN with count 37
        do_reset();
        cycle(1, C_RUN, 0);
        while (m_count < 37) cycle(0, C_CLEAR, 0);
        chk("t1_cnt37", 32'(o_cycle_count), 32'd37);
        do_reset();

        // 2: HALT decoded after 10 RUN cycles, drain, halt
        cycle(1, C_RUN, 0);
        repeat (10) cycle(0, C_CLEAR, 0);
        cycle(0, C_CLEAR, 1);
        repeat (N_DRAIN) cycle(0, C_CLEAR, 0);
        chk("t2_state", 32'(o_state),       32'd4);
        chk("t2_done",  32'(o_done),        32'd1);
        chk("t2_count", 32'(o_cycle_count), 32'd15);
        cycle(0, C_CLEAR, 0);
        chk("t2_done_once", 32'(o_done), 32'd0);

        // 3: three single steps
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1, C_STEP, 0);
            chk("t3_ready", 32'(o_cmd_ready), 32'd0);
            cycle(0, C_CLEAR, 0);
            chk("t3_step_done", 32'(o_step_done), 32'd1);
        end
        chk("t3_count", 32'(o_cycle_count), 32'd3);

        // 4: HALT command and HALT decode on the same edge
        do_reset();
        cycle(1, C_RUN, 0);
        repeat (3) cycle(0, C_CLEAR, 0);
        cycle(1, C_HALT, 1);
        done_seen = 0;
        for (int k = 0; k < N_DRAIN + 3; k++) begin
            cycle(0, C_CLEAR, 0);
            done_seen += int'(o_done);
        end
        chk("t4_done_count", 32'(done_seen), 32'd1);

        // 5: STEP hits a HALT, then CLEAR_CNT while HALTED
        do_reset();
        cycle(1, C_STEP, 0);
        cycle(0, C_CLEAR, 1);
        chk("t5_no_step_done", 32'(o_step_done), 32'd0);
        chk("t5_drain",        32'(o_state),     32'd3);
        repeat (N_DRAIN) cycle(0, C_CLEAR, 0);
        cycle(1, C_CLEAR, 0);
        chk("t5_cleared", 32'(o_cycle_count), 32'd0);
        chk("t5_halted",  32'(o_state),       32'd4);

        // 6: saturation
        do_reset();
        cycle(1, C_RUN, 0);
        while (m_count < CNT_MAX - 1) cycle(0, C_CLEAR, 0);
        repeat (5) cycle(0, C_CLEAR, 0);
        chk("t6_saturate", 32'(o_cycle_count), 32'(CNT_MAX));

        // Random traffic with occasional resets to escape HALTED
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 59) == 0)
                do_reset();
            else
                cycle(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
